// File: rtl/tile_row_engine_pkg.sv
// Shared definitions for the tile-row game engine: game-state encodings and the
// LFSR feedback used by every block that draws pseudo-random lanes.
package tile_row_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } game_state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Galois form: shift right, fold the taps in when a one falls out of bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/tile_lfsr.sv
// 16-bit Galois LFSR that advances only when step is high; shared with the audio block.
module tile_lfsr
    import tile_row_engine_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] value
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= SEED;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/tile_row_engine.sv
// Piano-tiles board state: spawns tiles at the top row, shifts them down, judges
// key presses against the hit row, and keeps the score and IDLE/RUN/OVER state.
module tile_row_engine
    import tile_row_engine_pkg::*;
#(
    parameter int          LANES   = 4,
    parameter int          ROWS    = 7,
    parameter int          SCORE_W = 16,
    parameter logic [15:0] SEED    = 16'hACE1,
    localparam int         LW      = $clog2(LANES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 shift,
    input  logic [LANES-1:0]     key,
    output logic [ROWS*LW-1:0]   row_lane,
    output logic [ROWS-1:0]      row_valid,
    output logic                 hit,
    output logic                 wrong,
    output logic                 miss,
    output logic [SCORE_W-1:0]   score,
    output logic [1:0]           state
);

    game_state_e      state_q;
    logic [15:0]      lfsr_value;
    logic [LANES-1:0] lane_onehot;
    logic             in_run;
    logic             judge;
    logic             do_hit;
    logic             do_wrong;
    logic             shift_req;
    logic             do_miss;
    logic             shift_go;
    logic             start_go;
    logic             unused_lfsr_bits;

    assign state = state_q;

    // start, shift and key are single-cycle pulses with no back-pressure: each
    // is acted on in the cycle it is high and its result is registered for the next.
    assign lane_onehot = LANES'(1) << row_lane[LW-1:0];
    assign in_run      = (state_q == ST_RUN);
    assign judge       = in_run && (|key) && row_valid[0];
    assign do_hit      = judge && (key == lane_onehot);
    assign do_wrong    = judge && (key != lane_onehot);
    assign shift_req   = in_run && shift && !do_wrong;
    // A tile hit this cycle is gone before the shift, so it cannot also be missed.
    assign do_miss     = shift_req && row_valid[0] && !do_hit;
    assign shift_go    = shift_req && !do_miss;
    assign start_go    = !in_run && start;

    tile_lfsr #(.SEED(SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .step  (shift_go),
        .value (lfsr_value)
    );

    assign unused_lfsr_bits = ^lfsr_value[15:LW];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                row_valid[r]            <= 1'b0;
                row_lane[r*LW +: LW]    <= '0;
            end else if (start_go) begin
                row_valid[r]            <= 1'b0;
            end else if (shift_go) begin
                if (r == ROWS - 1) begin
                    row_valid[r]         <= 1'b1;
                    row_lane[r*LW +: LW] <= lfsr_value[LW-1:0];
                end else begin
                    row_valid[r]         <= row_valid[(r+1) % ROWS];
                    row_lane[r*LW +: LW] <= row_lane[((r+1) % ROWS)*LW +: LW];
                end
            end else if (r == 0 && do_hit) begin
                row_valid[r]            <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            score   <= '0;
            hit     <= 1'b0;
            wrong   <= 1'b0;
            miss    <= 1'b0;
        end else begin
            hit   <= 1'b0;
            wrong <= 1'b0;
            miss  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        score   <= '0;
                    end
                end
                ST_RUN: begin
                    if (do_wrong) begin
                        wrong   <= 1'b1;
                        state_q <= ST_OVER;
                    end else begin
                        if (do_hit) begin
                            hit <= 1'b1;
                            if (score != '1) begin
                                score <= score + SCORE_W'(1);
                            end
                        end
                        if (do_miss) begin
                            miss    <= 1'b1;
                            state_q <= ST_OVER;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_row_engine.sv
// Directed bench for tile_row_engine (4 lanes, 7 rows, 3-bit score so saturation is reachable).
module tb_tile_row_engine;

    localparam int LANES   = 4;
    localparam int ROWS    = 7;
    localparam int SCORE_W = 3;
    localparam int LW      = 2;

    logic                 clock;
    logic                 reset;
    logic                 start;
    logic                 shift;
    logic [LANES-1:0]     key;
    logic [ROWS*LW-1:0]   row_lane;
    logic [ROWS-1:0]      row_valid;
    logic                 hit;
    logic                 wrong;
    logic                 miss;
    logic [SCORE_W-1:0]   score;
    logic [1:0]           state;

    int checks = 0;
    int errors = 0;

    tile_row_engine #(
        .LANES   (LANES),
        .ROWS    (ROWS),
        .SCORE_W (SCORE_W),
        .SEED    (16'hACE1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .shift     (shift),
        .key       (key),
        .row_lane  (row_lane),
        .row_valid (row_valid),
        .hit       (hit),
        .wrong     (wrong),
        .miss      (miss),
        .score     (score),
        .state     (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step(input logic [3:0] k, input logic sh, input logic st);
        @(negedge clock);
        key   = k;
        shift = sh;
        start = st;
        @(posedge clock);
        #1;
        key   = '0;
        shift = 1'b0;
        start = 1'b0;
    endtask

    // Pulses packed as {hit, wrong, miss}.
    function automatic logic [2:0] pulses();
        return {hit, wrong, miss};
    endfunction

    // Lanes drawn from SEED 16'hACE1: s0..s13 = 1,0,0,0,2,3,3,1,0,2,1,0,0,2
    initial begin
        reset = 1'b1;
        start = 1'b0;
        shift = 1'b0;
        key   = '0;
        #23;
        reset = 1'b0;

        check("reset_state", 32'(state), 32'h0);
        check("reset_score", 32'(score), 32'h0);
        check("reset_valid", 32'(row_valid), 32'h0);
        check("reset_lane", 32'(row_lane), 32'h0);
        check("reset_pulses", 32'(pulses()), 32'h0);

        step(4'b0001, 1'b1, 1'b0);
        check("idle_ignores_state", 32'(state), 32'h0);
        check("idle_ignores_valid", 32'(row_valid), 32'h0);

        // Game 1
        step(4'b0000, 1'b0, 1'b1);
        check("start_run", 32'(state), 32'h1);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1, 1'b0);
        check("fill6_valid", 32'(row_valid), 32'h7E);
        step(4'b0000, 1'b1, 1'b0);
        check("fill7_valid", 32'(row_valid), 32'h7F);
        check("fill7_lane0", 32'(row_lane[1:0]), 32'h1);
        check("fill7_lanes", 32'(row_lane), 32'h3E01);
        check("fill_no_miss", 32'(pulses()), 32'h0);

        step(4'b0010, 1'b0, 1'b0);
        check("hit1_pulse", 32'(pulses()), 32'h4);
        check("hit1_score", 32'(score), 32'h1);
        check("hit1_valid", 32'(row_valid), 32'h7E);
        step(4'b0000, 1'b0, 1'b0);
        check("hit1_pulse_clear", 32'(pulses()), 32'h0);

        step(4'b0000, 1'b1, 1'b0);
        check("shift_after_hit_no_miss", 32'(pulses()), 32'h0);
        check("shift_after_hit_state", 32'(state), 32'h1);
        check("shift_after_hit_valid", 32'(row_valid), 32'h7F);

        step(4'b0001, 1'b1, 1'b0);
        check("hit_shift_pulse", 32'(pulses()), 32'h4);
        check("hit_shift_score", 32'(score), 32'h2);
        check("hit_shift_valid", 32'(row_valid), 32'h7F);
        check("hit_shift_lane0", 32'(row_lane[1:0]), 32'h0);

        step(4'b0001, 1'b0, 1'b0);
        check("hit3_score", 32'(score), 32'h3);
        step(4'b0001, 1'b1, 1'b0);
        check("empty_row_press_pulses", 32'(pulses()), 32'h0);
        check("empty_row_press_score", 32'(score), 32'h3);
        check("empty_row_press_valid", 32'(row_valid), 32'h7F);
        step(4'b0001, 1'b1, 1'b0);
        check("hit4_score", 32'(score), 32'h4);
        check("hit4_lane0", 32'(row_lane[1:0]), 32'h2);
        step(4'b0100, 1'b0, 1'b0);
        check("hit5_score", 32'(score), 32'h5);

        step(4'b0000, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        check("hit6_score", 32'(score), 32'h6);
        step(4'b1000, 1'b1, 1'b0);
        check("hit7_score", 32'(score), 32'h7);
        step(4'b0010, 1'b0, 1'b0);
        check("sat_hit_pulse", 32'(pulses()), 32'h4);
        check("sat_score_holds", 32'(score), 32'h7);

        // Asynchronous reset mid-game
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("async_reset_state", 32'(state), 32'h0);
        check("async_reset_score", 32'(score), 32'h0);
        check("async_reset_valid", 32'(row_valid), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Game 2: LFSR reseeded, so the board matches game 1's fill
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(4'b0000, 1'b1, 1'b0);
        check("reseed_lanes", 32'(row_lane), 32'h3E01);
        step(4'b0011, 1'b1, 1'b0);
        check("wrong_pulse", 32'(pulses()), 32'h2);
        check("wrong_state", 32'(state), 32'h2);
        check("wrong_valid_frozen", 32'(row_valid), 32'h7F);
        check("wrong_lane_frozen", 32'(row_lane), 32'h3E01);
        step(4'b0000, 1'b1, 1'b0);
        check("over_shift_ignored", 32'(row_lane), 32'h3E01);
        step(4'b0010, 1'b0, 1'b0);
        check("over_key_ignored", 32'(pulses()), 32'h0);
        check("over_key_score", 32'(score), 32'h0);

        // Game 3: LFSR continues from s7
        step(4'b0000, 1'b0, 1'b1);
        check("restart_state", 32'(state), 32'h1);
        check("restart_valid", 32'(row_valid), 32'h0);
        check("restart_score", 32'(score), 32'h0);
        for (int i = 0; i < 7; i++) step(4'b0000, 1'b1, 1'b0);
        check("no_reseed_lanes", 32'(row_lane), 32'h2061);
        step(4'b0000, 1'b0, 1'b1);
        check("start_in_run_state", 32'(state), 32'h1);
        check("start_in_run_valid", 32'(row_valid), 32'h7F);
        step(4'b0000, 1'b1, 1'b0);
        check("miss_pulse", 32'(pulses()), 32'h1);
        check("miss_state", 32'(state), 32'h2);
        check("miss_frozen", 32'(row_lane), 32'h2061);
        step(4'b0000, 1'b0, 1'b1);
        check("miss_restart_state", 32'(state), 32'h1);
        check("miss_restart_valid", 32'(row_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
